// File: rtl/ram_burst_reader.sv
// Burst read engine for the 64x8 synchronous-read RAM: turns (addr, len) requests into an in-order valid/ready word stream.
// Define RAM_BURST_READER_WRAP_EN to let bursts wrap from the top address back to 0.
module ram_burst_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 7
) (
  input  logic              read_clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a read_clk edge where valid && ready are
  // both high; once valid is raised, it and its payload hold until that edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1 << ADDR_W);

  state_t              state, state_nxt;
  logic                init_done;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remaining;
  logic                inflight, inflight_last;
  logic [DATA_W-1:0]   buf_data [2];
  logic                buf_last [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          buf_count;

  logic                accept, req_bad, accept_ok;
  logic                pop, push, issue, last_issue, drain_done;
  logic [SUM_W-1:0]    span_end;
  logic [2:0]          credit_use;

  assign accept   = req_valid && req_ready;
  assign span_end = SUM_W'(req_addr) + SUM_W'(req_len);

`ifdef RAM_BURST_READER_WRAP_EN
  assign req_bad = (req_len == '0) || (SUM_W'(req_len) > DEPTH);
`else
  assign req_bad = (req_len == '0) || (SUM_W'(req_len) > DEPTH) || (span_end > DEPTH);
`endif

  assign accept_ok = accept && !req_bad;

  // read_addr is preloaded on acceptance, so an "issue" is the edge where the
  // RAM samples it; the word then lands in the buffer one edge later.
  assign pop        = out_valid && out_ready;
  assign push       = inflight;
  assign credit_use = {1'b0, buf_count} + {2'b00, inflight};
  assign issue      = (state == RUN) && (credit_use < (pop ? 3'd3 : 3'd2));
  assign last_issue = issue && (remaining == LEN_W'(1));
  assign drain_done = !inflight && ((buf_count == 2'd0) || (buf_count == 2'd1 && pop));

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_ok)  state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && init_done;
    busy      = (state != IDLE);
    state_dbg = state;
  end

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done     <= 1'b0;
      err           <= 1'b0;
      read_addr     <= '0;
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_data[0]   <= '0;
      buf_data[1]   <= '0;
      buf_last[0]   <= 1'b0;
      buf_last[1]   <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      buf_count     <= 2'd0;
    end else begin
      init_done     <= 1'b1;
      err           <= accept && req_bad;
      inflight      <= issue;
      inflight_last <= last_issue;
      if (accept_ok) begin
        read_addr <= req_addr;
        addr_q    <= req_addr + ADDR_W'(1);
        remaining <= req_len;
      end else if (issue) begin
        remaining <= remaining - LEN_W'(1);
        // Hold read_addr after the final issue so it never steps past the burst.
        if (!last_issue) begin
          read_addr <= addr_q;
          addr_q    <= addr_q + ADDR_W'(1);
        end
      end
      if (push) begin
        buf_data[wr_ptr] <= q;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 2'd1;
        2'b01:   buf_count <= buf_count - 2'd1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  always_comb begin
    out_valid = (buf_count != 2'd0);
    out_data  = buf_data[rd_ptr];
    out_last  = out_valid && buf_last[rd_ptr];
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: a behavioural 64x8 RAM holding mem[i]=i, a vector table, corner-case sequences
// and a queue scoreboard checking every handshaken word.
module tb_ram_burst_reader;

`ifdef RAM_BURST_READER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       read_clk, rst_n;
  logic       req_valid, req_ready;
  logic [5:0] req_addr, read_addr;
  logic [6:0] req_len;
  logic [7:0] q, out_data;
  logic       out_valid, out_ready, out_last, busy, err;
  logic [1:0] state_dbg;

  logic [7:0] mem [64];

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int ready_mode = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [8:0] held;

  typedef struct {
    logic [5:0] addr;
    logic [6:0] len;
    int         mode;
    bit         exp_err;
  } vec_t;

  vec_t vecs [8];

  ram_burst_reader dut (
    .read_clk (read_clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .read_addr(read_addr),
    .q        (q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .err      (err),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  end

  always @(posedge read_clk) q <= mem[read_addr];

  // consumer ready pattern: 0 = always, 1 = repeating 1-0-0-1, 2 = random
  always @(posedge read_clk) begin
    logic [3:0] pat;
    #1;
    cyc++;
    pat = 4'b1001;
    case (ready_mode)
      1:       out_ready = pat[cyc % 4];
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge read_clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_payload", 32'({out_last, out_data}), 32'(held));
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", {out_last, out_data}, $time);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            bad++;
            $display("FAIL word: got %0h expected %0h at %0t", {out_last, out_data}, e, $time);
          end
        end
        pops++;
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
    end
  end

  task automatic push_expect(input int addr, input int len);
    for (int i = 0; i < len; i++)
      exp_q.push_back({1'(i == len - 1), 8'((addr + i) % 64)});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge read_clk); #1;
      n++;
    end
    check("req_ready_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge read_clk); #1;
      n++;
    end
    check("burst_timeout", 32'(n < 500), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input int addr, input int len, input int mode, input bit exp_err);
    ready_mode = mode;
    wait_ready();
    req_addr  = 6'(addr);
    req_len   = 7'(len);
    req_valid = 1'b1;
    @(posedge read_clk);
    if (!exp_err) push_expect(addr, len);
    #1;
    req_valid = 1'b0;
    check("err_pulse", 32'(err), 32'(exp_err));
    if (!exp_err) check("read_addr_load", 32'(read_addr), 32'(addr));
    @(posedge read_clk); #1;
    check("err_one_cycle", 32'(err), 32'd0);
    if (exp_err) begin
      check("rej_busy", 32'(busy), 32'd0);
      check("rej_req_ready", 32'(req_ready), 32'd1);
      check("rej_out_valid", 32'(out_valid), 32'd0);
      @(posedge read_clk); #1;
      check("rej_no_words", 32'(out_valid), 32'd0);
    end else begin
      wait_done();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    vecs[0] = '{6'd5,  7'd4,  0, 1'b0};
    vecs[1] = '{6'd0,  7'd64, 1, 1'b0};
    vecs[2] = '{6'd62, 7'd4,  0, !WRAP};
    vecs[3] = '{6'd0,  7'd0,  0, 1'b1};
    vecs[4] = '{6'd0,  7'd65, 0, 1'b1};
    vecs[5] = '{6'd10, 7'd7,  2, 1'b0};
    vecs[6] = '{6'd63, 7'd1,  2, 1'b0};
    vecs[7] = '{6'd60, 7'd5,  2, !WRAP};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b1;
    #22;
    check_reset_outputs("reset");
    @(posedge read_clk); #2;
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge read_clk); #1;
    check("ready_after_edge", 32'(req_ready), 32'd1);

    // latency and streaming: addr 5, len 4, consumer always ready
    ready_mode = 0;
    req_addr = 6'd5; req_len = 7'd4; req_valid = 1'b1;
    @(posedge read_clk);
    push_expect(5, 4);
    #1;
    req_valid = 1'b0;
    check("lat_read_addr", 32'(read_addr), 32'd5);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_req_ready", 32'(req_ready), 32'd0);
    check("lat_valid_e0", 32'(out_valid), 32'd0);
    @(posedge read_clk); #1;
    check("lat_valid_e1", 32'(out_valid), 32'd0);
    @(posedge read_clk); #1;
    check("lat_valid_e2", 32'(out_valid), 32'd1);
    check("lat_first_data", 32'(out_data), 32'd5);
    for (int k = 1; k < 4; k++) begin
      @(posedge read_clk); #1;
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(5 + k));
      check("stream_busy", 32'(busy), 32'd1);
    end
    @(posedge read_clk); #1;
    check("end_busy", 32'(busy), 32'd0);
    check("end_req_ready", 32'(req_ready), 32'd1);
    check("end_out_valid", 32'(out_valid), 32'd0);

    // vector table
    for (int i = 0; i < 8; i++)
      run_vec(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].exp_err);

    // reset in the middle of a 10-word burst
    ready_mode = 0;
    wait_ready();
    base = pops;
    req_addr = 6'd0; req_len = 7'd10; req_valid = 1'b1;
    @(posedge read_clk);
    push_expect(0, 10);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (pops < base + 3 && n < 100) begin
      @(posedge read_clk); #1;
      n++;
    end
    check("mid_burst_reach", 32'(pops - base), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge read_clk); #2;
    rst_n = 1'b1;
    @(posedge read_clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    run_vec(20, 2, 0, 1'b0);

    // back-to-back: second request held while the first burst runs
    ready_mode = 0;
    wait_ready();
    req_addr = 6'd30; req_len = 7'd3; req_valid = 1'b1;
    @(posedge read_clk);
    push_expect(30, 3);
    #1;
    req_addr = 6'd40; req_len = 7'd2;
    n = 0;
    while (!req_ready && n < 50) begin
      check("b2b_ready_low", 32'(req_ready), 32'd0);
      @(posedge read_clk); #1;
      n++;
    end
    check("b2b_first_done", 32'(exp_q.size()), 32'd0);
    check("b2b_busy_low", 32'(busy), 32'd0);
    @(posedge read_clk);
    push_expect(40, 2);
    #1;
    req_valid = 1'b0;
    check("b2b_read_addr", 32'(read_addr), 32'd40);
    check("b2b_busy", 32'(busy), 32'd1);
    @(posedge read_clk); #1;
    check("b2b_valid_e1", 32'(out_valid), 32'd0);
    @(posedge read_clk); #1;
    check("b2b_valid_e2", 32'(out_valid), 32'd1);
    check("b2b_data", 32'(out_data), 32'd40);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Single-clock burst read engine that drives the read port of the team's 64x8 synchronous-read dual-port RAM. It accepts a (start address, length) request and presents the addressed words in order as a valid/ready stream. It absorbs the RAM's one-cycle read latency and downstream back-pressure with a 2-entry output buffer, and sustains one word per cycle when the consumer is always ready. It sits on the read side of the RAM, opposite the existing write-side logic.

## Interface
- ADDR_W, 6, RAM address width (64 locations)
- DATA_W, 8, RAM data width
- LEN_W, 7, burst length width (lengths 1..64)

- read_clk  in  1  sole clock; also drives the RAM read port
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  burst request valid
- req_ready  out  1  engine can accept a request
- req_addr  in  ADDR_W  first word address
- req_len  in  LEN_W  number of words
- read_addr  out  ADDR_W  to RAM read_addr; registered
- q  in  DATA_W  from RAM q; valid the cycle after the edge that sampled read_addr
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  stream word
- out_last  out  1  marks final word of burst
- busy  out  1  burst in progress (RUN or DRAIN)
- err  out  1  one-cycle pulse on rejected request

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: req_ready=1. On req_valid&&req_ready, validate the request.
  - Invalid: req_len==0 or req_len>64, plus the range rule under Configuration. Pulse err for 1 cycle, stay in IDLE, emit no words.
  - Valid: load addr counter=req_addr and remaining=req_len, go to RUN, req_ready=0.
- RUN: issue one read per cycle while credit allows.
  - Credit rule: issue iff buf_count + inflight - pop < 2, where pop = out_valid&&out_ready this cycle.
  - Issue: read_addr<=addr, addr<=addr+1 (6-bit), remaining<=remaining-1, set inflight.
  - Last issue: go to DRAIN.
- DRAIN: no new issues. Return to IDLE once inflight==0 and buf_count==0, i.e. after the last word handshakes.
- Capture: a word is pushed into the buffer from q one cycle after its issue. Output is the buffer head. The buffer never overflows by construction.
- out_last is tagged at issue of the final address and travels with that word.
- Output contract: out_data and out_last are stable while out_valid&&!out_ready. out_valid never drops without a handshake.
- Reset, including mid-burst: FSM to IDLE, buffer and inflight flushed, no out_last emitted for the aborted burst. RAM contents are unaffected.

## Timing
- Reset values: req_ready=0, read_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, err=0.
- req_ready rises at the first read_clk edge after rst_n deasserts.
- Acceptance edge E0: read_addr=req_addr after E0; RAM samples at E1; word captured at E2. out_valid=1 after E2, so first-word latency is 2 cycles.
- With out_ready held high: N words on N consecutive cycles. out_last is on word N. busy falls and req_ready rises at the edge that completes the last handshake.
- err asserts the cycle after the rejecting acceptance edge, for exactly 1 cycle.
- Back-pressure: with out_ready low, at most 2 words are buffered and issuing stops. The first word after out_ready returns appears on the same cycle, with no bubble.

## Configuration
- RAM_BURST_READER_WRAP_EN defined: address counter wraps 63→0. Any req_addr with req_len 1..64 is valid.
- Not defined: a request with req_addr+req_len>64 is invalid and gets an err pulse with no words. Addresses never wrap.

## Test plan
- RAM preloaded with mem[i]=i. Request addr=5, len=4, out_ready=1 → out_data 5,6,7,8 on consecutive cycles; out_valid first high 2 cycles after acceptance; out_last only on 8; busy low and req_ready high after.
- addr=0, len=64, out_ready toggling 1-0-0-1 → all 64 words 0..63 in order, none duplicated or dropped, at most 2 outstanding; data stable while stalled.
- addr=62, len=4 → with WRAP_EN: 62,63,0,1 with last on 1. Without: err 1-cycle pulse, no out_valid, req_ready stays 1.
- len=0 and len=65 → err pulse each, no words, engine stays IDLE.
- rst_n low after word 3 of a 10-word burst → all outputs at reset values immediately. A new request addr=20, len=2 then yields 20,21 with last on 21, and no stale words.
- Back-to-back: second request presented while busy → req_ready=0 until the first burst's last handshake; second burst starts 2 cycles after its acceptance.
